// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block producer: FSM encodings and
// padding constants.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    // Padding word that starts the trailer when the message ends on a word boundary.
    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          BLOCK_WORDS = 16;

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects a big-endian 32-bit word stream into
// 512-bit blocks, appends the 0x80 marker, zero fill and the 64-bit bit
// length, and hands blocks to the core with first/last flags.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic [511:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_first,
    output logic         block_last
);

    state_t            state_reg;
    state_t            ret_state_reg;
    logic [31:0]       buf_reg [0:BLOCK_WORDS-1];
    logic [4:0]        widx_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              pad_pend_reg;
    logic              first_flag_reg;
    logic              in_ready_reg;
    logic              block_valid_reg;
    logic              block_last_reg;

    logic [2:0]        n_eff;
    logic [63:0]       len_ext;

    // Keep the top n message bytes of the final word and drop the 0x80
    // marker into the first unused byte. A full word is passed through; its
    // marker is written later as a separate padding word.
    function automatic logic [31:0] byte_pad(input logic [31:0] d, input logic [2:0] n);
        logic [31:0] w;
        case (n)
            3'd0:    w = PAD_WORD;
            3'd1:    w = {d[31:24], 24'h80_0000};
            3'd2:    w = {d[31:16], 16'h8000};
            3'd3:    w = {d[31:8],  8'h80};
            default: w = d;
        endcase
        return w;
    endfunction

    // Effective byte count of the incoming word: 4 unless it closes the
    // message, and out-of-range counts saturate at a full word.
    always_comb begin
        n_eff = 3'd4;
        if (in_last && (in_nbytes < 3'd4)) begin
            n_eff = in_nbytes;
        end
    end

    assign len_ext = 64'(len_reg);

    // Main FSM: fill from the input stream, pad, then hold the block until the core takes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= S_FILL;
            ret_state_reg   <= S_FILL;
            widx_reg        <= '0;
            len_reg         <= '0;
            pad_pend_reg    <= 1'b0;
            first_flag_reg  <= 1'b1;
            in_ready_reg    <= 1'b0;
            block_valid_reg <= 1'b0;
            block_last_reg  <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_FILL: begin
                    if (!in_ready_reg) begin
                        // First cycle out of reset: open the input next cycle.
                        in_ready_reg <= 1'b1;
                    end else if (in_valid) begin
                        len_reg <= len_reg + LEN_W'({n_eff, 3'b000});
                        if (!in_last) begin
                            buf_reg[widx_reg[3:0]] <= in_data;
                            widx_reg               <= widx_reg + 5'd1;
                            if (widx_reg == 5'd15) begin
                                state_reg       <= S_EMIT;
                                ret_state_reg   <= S_FILL;
                                block_last_reg  <= 1'b0;
                                block_valid_reg <= 1'b1;
                                in_ready_reg    <= 1'b0;
                            end
                        end else begin
                            in_ready_reg <= 1'b0;
                            state_reg    <= S_PAD;
                            if (n_eff == 3'd0) begin
                                // Nothing to store; the marker goes in as a full padding word.
                                pad_pend_reg <= 1'b1;
                            end else begin
                                buf_reg[widx_reg[3:0]] <= byte_pad(in_data, n_eff);
                                widx_reg               <= widx_reg + 5'd1;
                                pad_pend_reg           <= (n_eff == 3'd4);
                            end
                        end
                    end
                end

                S_PAD: begin
                    if (widx_reg == 5'd16) begin
                        // Block full before the trailer fits: emit and continue padding.
                        state_reg       <= S_EMIT;
                        ret_state_reg   <= S_PAD;
                        block_last_reg  <= 1'b0;
                        block_valid_reg <= 1'b1;
                    end else if ((widx_reg == 5'd14) && !pad_pend_reg) begin
                        buf_reg[14]     <= len_ext[63:32];
                        buf_reg[15]     <= len_ext[31:0];
                        state_reg       <= S_EMIT;
                        ret_state_reg   <= S_FILL;
                        block_last_reg  <= 1'b1;
                        block_valid_reg <= 1'b1;
                    end else begin
                        buf_reg[widx_reg[3:0]] <= pad_pend_reg ? PAD_WORD : 32'h0;
                        pad_pend_reg           <= 1'b0;
                        widx_reg               <= widx_reg + 5'd1;
                    end
                end

                S_EMIT: begin
                    if (block_ready) begin
                        block_valid_reg <= 1'b0;
                        widx_reg        <= '0;
                        if (block_last_reg) begin
                            state_reg      <= S_FILL;
                            len_reg        <= '0;
                            first_flag_reg <= 1'b1;
                            in_ready_reg   <= 1'b1;
                        end else begin
                            state_reg      <= ret_state_reg;
                            first_flag_reg <= 1'b0;
                            in_ready_reg   <= (ret_state_reg == S_FILL);
                        end
                    end
                end

                default: begin
                    state_reg    <= S_FILL;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // The block output is the word buffer itself, word 0 in the top bits.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block
            assign block[511-32*gi -: 32] = buf_reg[gi];
        end
    endgenerate

    assign in_ready    = in_ready_reg;
    assign block_valid = block_valid_reg;
    assign block_first = first_flag_reg;
    assign block_last  = block_last_reg;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: a byte-level FIPS 180-4 padding
// model produces expected blocks, a monitor compares every handshaken block.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic [511:0] block;
    logic         block_valid;
    logic         block_ready;
    logic         block_first;
    logic         block_last;

    int errors = 0;
    int checks = 0;
    bit hold_low = 1'b0;

    logic [511:0] model_q[$];
    logic [511:0] exp_blk_q[$];
    bit           exp_first_q[$];
    bit           exp_last_q[$];

    sha256_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes),
        .block(block), .block_valid(block_valid), .block_ready(block_ready),
        .block_first(block_first), .block_last(block_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
    function automatic void build_blocks(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        model_q.delete();
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
            model_q.push_back(blk);
        end
    endfunction

    function automatic void expect_msg(input logic [7:0] msg[$]);
        build_blocks(msg);
        for (int b = 0; b < model_q.size(); b++) begin
            exp_blk_q.push_back(model_q[b]);
            exp_first_q.push_back(b == 0);
            exp_last_q.push_back(b == model_q.size() - 1);
        end
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] n);
        int t = 0;
        in_data   = d;
        in_last   = last;
        in_nbytes = n;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                chk(1'b0, "in_ready_timeout", 512'(in_ready), 512'(1));
                break;
            end
        end
        sync();
        in_valid  = 1'b0;
        in_last   = 1'($urandom);
        in_data   = $urandom;
        in_nbytes = 3'($urandom);
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit alt_end);
        int          len = msg.size();
        int          nw  = (len + 3) / 4;
        int          n;
        logic [31:0] d;
        if (len == 0) begin
            send_word($urandom, 1'b1, 3'd0);
        end else begin
            for (int w = 0; w < nw; w++) begin
                n = (len - 4*w >= 4) ? 4 : len - 4*w;
                d = $urandom;
                for (int k = 0; k < n; k++) d[31-8*k -: 8] = msg[4*w + k];
                if (w != nw - 1) begin
                    send_word(d, 1'b0, 3'($urandom));
                end else if (alt_end && n == 4) begin
                    send_word(d, 1'b0, 3'($urandom));
                    send_word($urandom, 1'b1, 3'd0);
                end else begin
                    send_word(d, 1'b1, 3'(n));
                end
                if ($urandom_range(0, 3) == 0) sync();
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_blk_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(exp_blk_q.size() == 0, "drain_timeout", 512'(exp_blk_q.size()), 512'(0));
        sync();
    endtask

    // Core-side ready: random, or forced low for the stall test.
    initial begin
        block_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            block_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every emitted block must be stable until taken and match the model.
    initial begin
        logic [511:0] held_blk;
        logic [1:0]   held_fl;
        bit           held = 1'b0;
        logic [511:0] e;
        bit           ef, el;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held = 1'b0;
            end else if (block_valid) begin
                chk(!in_ready, "in_ready_during_emit", 512'(in_ready), 512'(0));
                if (held) begin
                    chk(block == held_blk, "block_stable", block, held_blk);
                    chk({block_first, block_last} == held_fl, "flags_stable",
                        512'({block_first, block_last}), 512'(held_fl));
                end
                if (block_ready) begin
                    held = 1'b0;
                    if (exp_blk_q.size() == 0) begin
                        chk(1'b0, "unexpected_block", block, '0);
                    end else begin
                        e  = exp_blk_q.pop_front();
                        ef = exp_first_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk(block == e, "block_data", block, e);
                        chk(block_first == ef, "block_first", 512'(block_first), 512'(ef));
                        chk(block_last == el, "block_last", 512'(block_last), 512'(el));
                        $display("block: first=%0d last=%0d word0=%08h word15=%08h",
                                 block_first, block_last, block[511:480], block[31:0]);
                    end
                end else begin
                    held     = 1'b1;
                    held_blk = block;
                    held_fl  = {block_first, block_last};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0]   abc[$];
        logic [7:0]   empty_msg[$];
        logic [7:0]   m56[$];
        logic [7:0]   m64[$];
        logic [7:0]   m55[$];
        logic [7:0]   rnd[$];
        logic [511:0] cap;
        logic [1:0]   cap_fl;
        int           t;

        abc = '{8'h61, 8'h62, 8'h63};
        for (int i = 0; i < 56; i++) m56.push_back(8'(i + 1));
        for (int i = 0; i < 64; i++) m64.push_back(8'(8'hA0 ^ i));
        for (int i = 0; i < 55; i++) m55.push_back(8'(3 * i));

        // Pin the model with hand-computed blocks.
        build_blocks(abc);
        chk(model_q.size() == 1, "model_abc_count", 512'(model_q.size()), 512'(1));
        chk(model_q[0] == {32'h61626380, {13{32'h0}}, 32'h0, 32'h18}, "model_abc", model_q[0],
            {32'h61626380, {13{32'h0}}, 32'h0, 32'h18});
        build_blocks(empty_msg);
        chk(model_q[0] == {32'h80000000, {15{32'h0}}}, "model_empty", model_q[0], {32'h80000000, {15{32'h0}}});
        build_blocks(m56);
        chk(model_q.size() == 2, "model_56_count", 512'(model_q.size()), 512'(2));
        chk(model_q[0][511-32*14 -: 32] == 32'h80000000, "model_56_w14", 512'(model_q[0][511-32*14 -: 32]), 512'(32'h80000000));
        chk(model_q[1] == {{15{32'h0}}, 32'h1C0}, "model_56_blk2", model_q[1], {{15{32'h0}}, 32'h1C0});
        build_blocks(m64);
        chk(model_q[1] == {32'h80000000, {14{32'h0}}, 32'h200}, "model_64_blk2", model_q[1],
            {32'h80000000, {14{32'h0}}, 32'h200});

        // Reset state.
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b0, "rst_in_ready", 512'(in_ready), 512'(0));
        chk(block_valid == 1'b0, "rst_block_valid", 512'(block_valid), 512'(0));
        chk(block_first == 1'b1, "rst_block_first", 512'(block_first), 512'(1));
        chk(block_last == 1'b0, "rst_block_last", 512'(block_last), 512'(0));
        chk(block == '0, "rst_block", block, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b0, "in_ready_release0", 512'(in_ready), 512'(0));
        @(negedge clk);
        chk(in_ready == 1'b1, "in_ready_release1", 512'(in_ready), 512'(1));
        sync();

        // Directed messages.
        expect_msg(abc);       send_msg(abc, 1'b0);
        expect_msg(empty_msg); send_msg(empty_msg, 1'b0);
        expect_msg(m56);       send_msg(m56, 1'b0);
        expect_msg(m64);       send_msg(m64, 1'b0);
        expect_msg(m64);       send_msg(m64, 1'b1);
        expect_msg(m55);       send_msg(m55, 1'b0);
        drain();

        // Stall: block_ready held low for 10 cycles while a block is presented.
        hold_low = 1'b1;
        expect_msg(abc);
        send_msg(abc, 1'b0);
        t = 0;
        while (!block_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(block_valid == 1'b1, "stall_block_valid", 512'(block_valid), 512'(1));
        cap    = block;
        cap_fl = {block_first, block_last};
        repeat (10) begin
            @(negedge clk);
            chk(block == cap && {block_first, block_last} == cap_fl && block_valid,
                "stall_hold", block, cap);
            chk(in_ready == 1'b0, "stall_in_ready", 512'(in_ready), 512'(0));
        end
        sync();
        hold_low = 1'b0;
        drain();

        // Reset in the middle of padding discards the message.
        send_word(32'h61626300, 1'b1, 3'd3);
        sync(); sync();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(block_valid == 1'b0, "midrst_block_valid", 512'(block_valid), 512'(0));
        chk(in_ready == 1'b0, "midrst_in_ready", 512'(in_ready), 512'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1, "midrst_in_ready_back", 512'(in_ready), 512'(1));
        sync();
        expect_msg(abc);
        send_msg(abc, 1'b0);

        // Random back-to-back messages.
        for (int m = 0; m < 40; m++) begin
            rnd.delete();
            for (int i = 0; i < int'($urandom_range(0, 140)); i++) rnd.push_back(8'($urandom));
            expect_msg(rnd);
            send_msg(rnd, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
